calc_key_sequencer: RTL

//   Front-end sequencer of the calculator. Debounces the four front-panel keys and turns each press into a 2-bit key code.

---
 rtl/calc_key_sequencer_if.sv | 31 +++
 rtl/calc_key_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer_if.sv
// Sequencer <-> datapath bus: next-state LUT lookup and ULA launch/complete.
//   lut_in    {state, key code} presented to the external next-state LUT
//   lut_out   next state returned by the LUT (combinational)
//   alu_a/b   captured operands, alu_op captured opcode
//   alu_start one-cycle launch pulse, alu_done completion pulse
//   alu_res   ULA result, valid in the alu_done cycle
interface calc_key_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
);
  logic [3:0]       lut_in;
  logic [1:0]       lut_out;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [WIDTH-1:0] alu_res;

  // Sequencer side
  modport master (
    output lut_in, alu_a, alu_b, alu_op, alu_start,
    input  lut_out, alu_done, alu_res
  );

  // LUT / ULA side
  modport slave (
    input  lut_in, alu_a, alu_b, alu_op, alu_start,
    output lut_out, alu_done, alu_res
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator front-end sequencer.
//   Debounces four raw keys, turns each accepted press into a 2-bit code,
//   steps the 2-bit calculator state through an external LUT, captures
//   operands/opcode from the switches and launches the ULA.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   key_num/key_op/key_eq/key_clr    raw bouncing keys
//   sw_data, sw_op                   operand and opcode switches
//   state                            current calculator state
//   result                           last latched ULA result
//   busy                             ULA operation in flight
//   bus (master)                     LUT and ULA signals
module calc_key_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OPW        = 3,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_num,
  input  logic                 key_op,
  input  logic                 key_eq,
  input  logic                 key_clr,
  input  logic [WIDTH-1:0]     sw_data,
  input  logic [OPW-1:0]       sw_op,
  output logic [1:0]           state,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  calc_key_sequencer_if.master bus
);

  localparam int unsigned NKEYS = 4;
  // Counter only needs to reach DEB_CYCLES-1: the last mismatching sample flips the level
  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'b00,
    ST_ENTRY_A = 2'b01,
    ST_ENTRY_B = 2'b10,
    ST_RESULT  = 2'b11
  } calc_state_e;

  typedef enum logic [1:0] {
    KEY_NUM = 2'b00,
    KEY_OP  = 2'b01,
    KEY_EQ  = 2'b10,
    KEY_CLR = 2'b11
  } key_code_e;

  // Bit index of each key equals its code
  logic [NKEYS-1:0] raw_keys;
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;
  logic [NKEYS-1:0] rise_c;

  assign raw_keys = {key_clr, key_eq, key_op, key_num};

  // Two-flop synchronizer for all keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_keys;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debouncer: level follows the synchronized sample after DEB_CYCLES disagreeing samples
  for (genvar k = 0; k < NKEYS; k++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise;

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      rise  = 1'b0;
      if (sync2_q[k] != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d = ~lvl_q;
          rise  = ~lvl_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign rise_c[k] = rise;
  end

  calc_state_e      state_q,  state_d;
  key_code_e        code_q,   code_d;
  logic             evt_q,    evt_d;
  logic [WIDTH-1:0] alu_a_q,  alu_a_d;
  logic [WIDTH-1:0] alu_b_q,  alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q,   busy_d;
  logic             start_c;

  // State / datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      code_q   <= KEY_NUM;
      evt_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      evt_q    <= evt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: event execution, ULA completion, press acceptance
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    evt_d    = 1'b0;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    busy_d   = busy_q;
    start_c  = 1'b0;

    // Event cycle: lut_in has been stable for a full cycle, so lut_out is trusted here only
    if (evt_q) begin
      state_d = calc_state_e'(bus.lut_out);
      unique case (code_q)
        KEY_NUM: begin
          if (state_q == ST_CLEAR || state_q == ST_ENTRY_A) begin
            alu_a_d = sw_data;
          end else begin
            alu_b_d = sw_data;
          end
        end
        KEY_OP: alu_op_d = sw_op;
        KEY_EQ: begin
          if (state_q == ST_ENTRY_B) begin
            start_c = 1'b1;
            busy_d  = 1'b1;
          end
        end
        KEY_CLR: begin
          alu_a_d  = '0;
          alu_b_d  = '0;
          alu_op_d = '0;
          result_d = '0;
        end
      endcase
    end

    // Completion only counts for an operation this block launched
    if (bus.alu_done && busy_q) begin
      result_d = bus.alu_res;
      busy_d   = 1'b0;
    end

    // Accept one press per event window; CLR > EQ > OP > NUM
    if ((|rise_c) && !busy_q && !evt_q) begin
      evt_d = 1'b1;
      if (rise_c[3]) begin
        code_d = KEY_CLR;
      end else if (rise_c[2]) begin
        code_d = KEY_EQ;
      end else if (rise_c[1]) begin
        code_d = KEY_OP;
      end else begin
        code_d = KEY_NUM;
      end
    end
  end

  assign bus.lut_in    = {state_q, code_q};
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  // Pure decode of registered state, so it is a clean single-cycle pulse
  assign bus.alu_start = start_c;
  assign state         = state_q;
  assign result        = result_q;
  assign busy          = busy_q;

endmodule
